count_display: RTL

Display back-end for the 8-bit free-running counter on `uo_out`. It takes the binary count and converts it to three BCD digits with a sequential add-3/shift (double-dabble) engine, then time-multiplexes those digits onto a 7-segment display with leading-zero blanking. In the tile top level, `value` is driven by `counter_out` and `sample` is tied high. `seg` drives `uo_out[6:0]`, and `an` drives `uio_out[2:0]` with `uio_oe[2:0]=3'b111`.

---
 rtl/count_display_pkg.sv | 48 ++++
 rtl/count_display_bin2bcd.sv | 79 +++++++
 rtl/count_display.sv | 114 +++++++++++
 3 files changed

// File: rtl/count_display_pkg.sv
// Shared constants, FSM encoding and 7-segment helpers for the count_display slice.
package count_display_pkg;

    localparam int BIN_W    = 8;
    localparam int BCD_W    = 12;
    localparam int N_DIGITS = 3;

    typedef logic [1:0] state_t;
    localparam state_t ST_IDLE  = 2'd0;
    localparam state_t ST_SHIFT = 2'd1;
    localparam state_t ST_DONE  = 2'd2;

    // Active-high segment patterns, bit order {g,f,e,d,c,b,a}
    localparam logic [6:0] SEG_0     = 7'b0111111;
    localparam logic [6:0] SEG_1     = 7'b0000110;
    localparam logic [6:0] SEG_2     = 7'b1011011;
    localparam logic [6:0] SEG_3     = 7'b1001111;
    localparam logic [6:0] SEG_4     = 7'b1100110;
    localparam logic [6:0] SEG_5     = 7'b1101101;
    localparam logic [6:0] SEG_6     = 7'b1111101;
    localparam logic [6:0] SEG_7     = 7'b0000111;
    localparam logic [6:0] SEG_8     = 7'b1111111;
    localparam logic [6:0] SEG_9     = 7'b1101111;
    localparam logic [6:0] SEG_BLANK = 7'b0000000;

    function automatic logic [6:0] seg_decode(input logic [3:0] nibble);
        logic [6:0] w_seg;
        case (nibble)
            4'd0:    w_seg = SEG_0;
            4'd1:    w_seg = SEG_1;
            4'd2:    w_seg = SEG_2;
            4'd3:    w_seg = SEG_3;
            4'd4:    w_seg = SEG_4;
            4'd5:    w_seg = SEG_5;
            4'd6:    w_seg = SEG_6;
            4'd7:    w_seg = SEG_7;
            4'd8:    w_seg = SEG_8;
            4'd9:    w_seg = SEG_9;
            default: w_seg = SEG_BLANK;
        endcase
        return w_seg;
    endfunction

    function automatic logic [3:0] add3_nibble(input logic [3:0] nibble);
        return (nibble >= 4'd5) ? (nibble + 4'd3) : nibble;
    endfunction

endpackage

// File: rtl/count_display_bin2bcd.sv
// Sequential double-dabble converter: one add-3/shift step per clock, result committed on DONE.
module bin2bcd_seq
    import count_display_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic [BIN_W-1:0] value,
    input  logic             sample,
    output logic [BCD_W-1:0] bcd,
    output logic             bcd_valid,
    output logic             busy
);

    state_t                   r_state;
    logic [BIN_W-1:0]         r_shreg;
    logic [BCD_W-1:0]         r_scratch;
    logic [BCD_W-1:0]         r_bcd;
    logic [3:0]               r_iter;
    logic                     r_bcd_valid;
    logic                     r_busy;
    logic [BCD_W-1:0]         w_adj;
    logic [BCD_W+BIN_W-1:0]   w_cat;

    // Add-3 correction on every nibble, then the joint left shift
    always_comb begin
        w_adj = {add3_nibble(r_scratch[11:8]), add3_nibble(r_scratch[7:4]),
                 add3_nibble(r_scratch[3:0])};
        w_cat = {w_adj, r_shreg} << 1;
    end

    // Converter FSM and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_shreg     <= {BIN_W{1'b0}};
            r_scratch   <= {BCD_W{1'b0}};
            r_bcd       <= {BCD_W{1'b0}};
            r_iter      <= 4'd0;
            r_bcd_valid <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            r_bcd_valid <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (sample) begin
                        r_shreg   <= value;
                        r_scratch <= {BCD_W{1'b0}};
                        r_iter    <= 4'd0;
                        r_busy    <= 1'b1;
                        r_state   <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    r_scratch <= w_cat[BCD_W+BIN_W-1:BIN_W];
                    r_shreg   <= w_cat[BIN_W-1:0];
                    r_iter    <= r_iter + 4'd1;
                    if (r_iter == 4'd7) begin
                        r_state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    r_bcd       <= r_scratch;
                    r_bcd_valid <= 1'b1;
                    r_busy      <= 1'b0;
                    r_state     <= ST_IDLE;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign bcd       = r_bcd;
    assign bcd_valid = r_bcd_valid;
    assign busy      = r_busy;

endmodule

// File: rtl/count_display.sv
// 7-segment back-end: BCD conversion of the counter value plus a multiplexed,
// leading-zero-blanked three-digit scanner.
module count_display
    import count_display_pkg::*;
#(
    parameter int SCAN_DIV       = 1024,
    parameter bit SEG_ACTIVE_LOW = 1'b0
)(
    input  logic             clk,
    input  logic             rst_n,
    input  logic [BIN_W-1:0] value,
    input  logic             sample,
    output logic [6:0]       seg,
    output logic [2:0]       an,
    output logic [BCD_W-1:0] bcd,
    output logic             bcd_valid,
    output logic             busy
);

    localparam int               DIV_W    = $clog2(SCAN_DIV);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
    localparam logic [1:0]       LAST_IDX = 2'(N_DIGITS - 1);

    logic [DIV_W-1:0] r_div;
    logic [1:0]       r_idx;
    logic [6:0]       r_seg;
    logic [2:0]       r_an;
    logic [BCD_W-1:0] w_bcd;
    logic             w_wrap;
    logic [1:0]       w_idx_next;
    logic [3:0]       w_nibble;
    logic             w_blank;
    logic [2:0]       w_an_raw;
    logic [6:0]       w_seg_raw;

    bin2bcd_seq u_bin2bcd (
        .clk       (clk),
        .rst_n     (rst_n),
        .value     (value),
        .sample    (sample),
        .bcd       (w_bcd),
        .bcd_valid (bcd_valid),
        .busy      (busy)
    );

    // Next digit index; an/seg are loaded from it so they switch together
    always_comb begin
        w_wrap = (r_div == DIV_LAST);
        if (w_wrap) begin
            if (r_idx == LAST_IDX) begin
                w_idx_next = 2'd0;
            end else begin
                w_idx_next = r_idx + 2'd1;
            end
        end else begin
            w_idx_next = r_idx;
        end
    end

    // Digit select from committed bcd with leading-zero blanking
    always_comb begin
        case (w_idx_next)
            2'd0: begin
                w_nibble = w_bcd[3:0];
                w_blank  = 1'b0;
                w_an_raw = 3'b001;
            end
            2'd1: begin
                w_nibble = w_bcd[7:4];
                w_blank  = (w_bcd[11:8] == 4'd0) && (w_bcd[7:4] == 4'd0);
                w_an_raw = 3'b010;
            end
            2'd2: begin
                w_nibble = w_bcd[11:8];
                w_blank  = (w_bcd[11:8] == 4'd0);
                w_an_raw = 3'b100;
            end
            default: begin
                w_nibble = 4'd0;
                w_blank  = 1'b1;
                w_an_raw = 3'b000;
            end
        endcase
        if (w_blank) begin
            w_seg_raw = SEG_BLANK;
        end else begin
            w_seg_raw = seg_decode(w_nibble);
        end
    end

    // Scan divider, digit index and polarity-adjusted output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_div <= {DIV_W{1'b0}};
            r_idx <= 2'd0;
            r_seg <= {7{SEG_ACTIVE_LOW}};
            r_an  <= {3{SEG_ACTIVE_LOW}};
        end else begin
            if (w_wrap) begin
                r_div <= {DIV_W{1'b0}};
            end else begin
                r_div <= r_div + DIV_W'(1);
            end
            r_idx <= w_idx_next;
            r_seg <= w_seg_raw ^ {7{SEG_ACTIVE_LOW}};
            r_an  <= w_an_raw ^ {3{SEG_ACTIVE_LOW}};
        end
    end

    assign seg = r_seg;
    assign an  = r_an;
    assign bcd = w_bcd;

endmodule
